// File: rtl/hub75_bcm_driver_pkg.sv
// Shared types and helpers for the HUB75 BCM scan driver.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  // Position of R/G/B inside one 3-bit plane field.
  localparam logic [1:0] R_OFS = 2'd2;
  localparam logic [1:0] G_OFS = 2'd1;
  localparam logic [1:0] B_OFS = 2'd0;

  function automatic int unsigned col_w(input int unsigned cols);
    return $clog2(cols);
  endfunction

  function automatic int unsigned plane_w(input int unsigned planes);
    return (planes > 1) ? $clog2(planes) : 1;
  endfunction

  // Wide enough to hold BASE_ON << (PLANES-1), including exact powers of two.
  function automatic int unsigned on_w(input int unsigned base_on, input int unsigned planes);
    return $clog2(base_on << (planes - 1)) + 1;
  endfunction

  // LSB of plane p inside a packed {.., R,G,B} pixel word.
  function automatic int unsigned plane_lsb(input int unsigned plane);
    return 3 * plane;
  endfunction

endpackage

// File: rtl/hub75_bcm_driver_if.sv
// Frame-buffer read port: 1-cycle read latency, top and bottom half-row pixels.
interface hub75_bcm_driver_if
  import hub75_pkg::*;
#(
  parameter int unsigned COLS     = 64,
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned PLANES   = 4
);
  localparam int unsigned COL_W = col_w(COLS);

  logic                  pix_rd;
  logic [ROW_BITS-1:0]   pix_row;
  logic [COL_W-1:0]      pix_col;
  logic [3*PLANES-1:0]   pix_top;
  logic [3*PLANES-1:0]   pix_bot;

  modport master (
    output pix_rd, pix_row, pix_col,
    input  pix_top, pix_bot
  );

  modport slave (
    input  pix_rd, pix_row, pix_col,
    output pix_top, pix_bot
  );
endinterface

// File: rtl/hub75_oe_timer.sv
// Per-plane display timer: loads BASE_ON<<plane, counts down while running,
// flags the final lit cycle.
module hub75_oe_timer
  import hub75_pkg::*;
#(
  parameter  int unsigned BASE_ON = 8,
  parameter  int unsigned PLANES  = 4,
  localparam int unsigned PL_W    = plane_w(PLANES),
  localparam int unsigned ON_W    = on_w(BASE_ON, PLANES)
)
(
  input  logic            clk_shift,
  input  logic            rst,
  input  logic            load,
  input  logic            run,
  input  logic [PL_W-1:0] plane,
  output logic            done
);

  logic [ON_W-1:0] cnt_q, cnt_d;

  // Next count: reload on latch, decrement while lit.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = ON_W'(BASE_ON) << plane;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign done = run && (cnt_q == ON_W'(1));

  // Count register.
  always_ff @(posedge clk_shift or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  a_base_on_nonzero: assert property (@(posedge clk_shift) disable iff (rst) (BASE_ON != 0))
    else $error("hub75_oe_timer: BASE_ON must be nonzero");

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 scan driver with binary-coded modulation over PLANES bit planes.
// Per row-plane: SHIFT (fetch + serialise COLS pixels), BLANK, LATCH, DISPLAY.
module hub75_bcm_driver
  import hub75_pkg::*;
#(
  parameter int unsigned COLS     = 64,
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned PLANES   = 4,
  parameter int unsigned BASE_ON  = 8
)
(
  input  logic                clk_shift,
  input  logic                rst,
  input  logic                en,
  hub75_bcm_driver_if.master  fb,
  output logic                r0,
  output logic                g0,
  output logic                b0,
  output logic                r1,
  output logic                g1,
  output logic                b1,
  output logic                sclk,
  output logic                lat,
  output logic                oe,
  output logic [ROW_BITS-1:0] row_addr,
  output logic                frame_done,
  output logic                busy
);

  localparam int unsigned COL_W = col_w(COLS);
  localparam int unsigned PL_W  = plane_w(PLANES);
  localparam int unsigned CNT_W = $clog2(2 * COLS + 2);

  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(2 * COLS + 1);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(2 * COLS - 1);
  localparam logic [CNT_W-1:0] RD_END  = CNT_W'(2 * COLS);
  localparam logic [CNT_W-1:0] SCLK_ST = CNT_W'(3);
  localparam logic [PL_W-1:0]  LAST_PL = PL_W'(PLANES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PL_W-1:0]     plane_q, plane_d;

  logic [5:0]          rgb_q, rgb_d;
  logic                pix_rd_q, pix_rd_d;
  logic [ROW_BITS-1:0] pix_row_q, pix_row_d;
  logic [COL_W-1:0]    pix_col_q, pix_col_d;
  logic                sclk_q, sclk_d;
  logic                lat_q, lat_d;
  logic                oe_q, oe_d;
  logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;

  logic                tmr_load, tmr_run, tmr_done;
  logic [2:0]          top_px, bot_px;

  assign tmr_load = (state_q == LATCH);
  assign tmr_run  = (state_q == DISPLAY);

  hub75_oe_timer #(
    .BASE_ON (BASE_ON),
    .PLANES  (PLANES)
  ) u_oe_timer (
    .clk_shift (clk_shift),
    .rst       (rst),
    .load      (tmr_load),
    .run       (tmr_run),
    .plane     (plane_q),
    .done      (tmr_done)
  );

  assign top_px = 3'(fb.pix_top >> plane_lsb(32'(plane_q)));
  assign bot_px = 3'(fb.pix_bot >> plane_lsb(32'(plane_q)));

  // Sequencing, counters and next values of all registered outputs.
  // Outputs are derived from the next state/count so they line up with state_q.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    plane_d      = plane_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_C) state_d = BLANK;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      BLANK:   state_d = LATCH;
      LATCH:   state_d = DISPLAY;
      DISPLAY: begin
        if (tmr_done) begin
          cnt_d   = '0;
          state_d = en ? SHIFT : IDLE;
          if (plane_q == LAST_PL) begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
            if (row_q == '1) frame_done_d = 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    pix_rd_d  = (state_d == SHIFT) && !cnt_d[0] && (cnt_d < RD_END);
    pix_col_d = pix_rd_d ? cnt_d[COL_W:1] : '0;
    pix_row_d = row_d;
    sclk_d    = (state_d == SHIFT) && cnt_d[0] && (cnt_d >= SCLK_ST);
    lat_d     = (state_d == LATCH);
    oe_d      = (state_d != DISPLAY);
    busy_d    = (state_d != IDLE);
    row_addr_d = lat_d ? row_q : row_addr_q;

    // Read data returns on odd cycles; capture it for the following two cycles.
    rgb_d = rgb_q;
    if ((state_q == SHIFT) && cnt_q[0] && (cnt_q <= LAST_RD)) begin
      rgb_d = {top_px[R_OFS], top_px[G_OFS], top_px[B_OFS],
               bot_px[R_OFS], bot_px[G_OFS], bot_px[B_OFS]};
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_shift or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      rgb_q        <= '0;
      pix_rd_q     <= 1'b0;
      pix_row_q    <= '0;
      pix_col_q    <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_q         <= 1'b1;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      rgb_q        <= rgb_d;
      pix_rd_q     <= pix_rd_d;
      pix_row_q    <= pix_row_d;
      pix_col_q    <= pix_col_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_q         <= oe_d;
      row_addr_q   <= row_addr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign fb.pix_rd  = pix_rd_q;
  assign fb.pix_row = pix_row_q;
  assign fb.pix_col = pix_col_q;
  assign {r0, g0, b0, r1, g1, b1} = rgb_q;
  assign sclk       = sclk_q;
  assign lat        = lat_q;
  assign oe         = oe_q;
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Self-checking bench for hub75_bcm_driver: event-level panel model plus
// directed scenarios and a randomized enable phase.
module tb_hub75_bcm_driver;

  localparam int unsigned COLS     = 4;
  localparam int unsigned ROW_BITS = 2;
  localparam int unsigned PLANES   = 2;
  localparam int unsigned BASE_ON  = 3;
  localparam int unsigned NROWS    = 1 << ROW_BITS;

  typedef logic [3*PLANES-1:0] pix_t;

  logic clk_shift = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic r0, g0, b0, r1, g1, b1, sclk, lat, oe, frame_done, busy;
  logic [ROW_BITS-1:0] row_addr;

  hub75_bcm_driver_if #(.COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES)) fb ();

  hub75_bcm_driver #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_ON(BASE_ON)
  ) dut (
    .clk_shift (clk_shift), .rst (rst), .en (en), .fb (fb),
    .r0 (r0), .g0 (g0), .b0 (b0), .r1 (r1), .g1 (g1), .b1 (b1),
    .sclk (sclk), .lat (lat), .oe (oe), .row_addr (row_addr),
    .frame_done (frame_done), .busy (busy)
  );

  always #5 clk_shift = ~clk_shift;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame buffer: one-cycle read latency, garbage when not read.
  pix_t mem_top [NROWS][COLS];
  pix_t mem_bot [NROWS][COLS];

  always @(posedge clk_shift) begin
    if (fb.pix_rd) begin
      fb.pix_top <= mem_top[fb.pix_row][fb.pix_col];
      fb.pix_bot <= mem_bot[fb.pix_row][fb.pix_col];
    end else begin
      fb.pix_top <= pix_t'($urandom);
      fb.pix_bot <= pix_t'($urandom);
    end
  end

  function automatic logic [5:0] exp_rgb(input int row, input int col, input int plane);
    pix_t t, b;
    t = mem_top[row][col];
    b = mem_bot[row][col];
    return {3'(t >> (3 * plane)), 3'(b >> (3 * plane))};
  endfunction

  // Panel-level model state.
  int exp_row = 0, exp_plane = 0;
  int cyc = 0, rd_start = -1, n_rd = 0, n_sclk = 0, oe_run = 0, lat_cnt = 0;
  bit sclk_prev = 0, oe_prev = 1, lat_prev = 0, wrap_now = 0;
  logic [ROW_BITS-1:0] ra_prev = '0;

  // Monitor: every row-plane must be COLS reads, COLS pulses, a latch, then
  // a lit window of BASE_ON<<plane cycles; frame_done after the last one.
  initial begin : monitor
    forever begin
      @(negedge clk_shift);
      cyc++;
      if (rst) begin
        exp_row = 0; exp_plane = 0; rd_start = -1; n_rd = 0; n_sclk = 0;
        oe_run = 0; sclk_prev = 0; oe_prev = 1; lat_prev = 0; ra_prev = '0;
      end else begin
        wrap_now = 0;
        if (oe && !oe_prev) begin
          check_eq("oe_low_len", 32'(oe_run), 32'(BASE_ON << exp_plane));
          oe_run = 0;
          exp_plane++;
          if (exp_plane == int'(PLANES)) begin
            exp_plane = 0;
            exp_row   = (exp_row + 1) % NROWS;
            wrap_now  = (exp_row == 0);
          end
        end
        check_eq("frame_done", 32'(frame_done), 32'(wrap_now));
        if (!oe) begin
          oe_run++;
          check_eq("sclk_while_lit", 32'(sclk), 0);
          check_eq("lat_while_lit", 32'(lat), 0);
        end
        if (!busy) check_eq("idle_blank", 32'(oe), 1);
        if (fb.pix_rd) begin
          if (rd_start < 0) rd_start = cyc;
          check_eq("rd_row", 32'(fb.pix_row), 32'(exp_row));
          check_eq("rd_col", 32'(fb.pix_col), 32'(n_rd));
          check_eq("rd_slot", 32'(cyc - rd_start), 32'(2 * n_rd));
          check_eq("rd_blank", 32'(oe), 1);
          n_rd++;
        end
        if (sclk && !sclk_prev) begin
          if (n_sclk < int'(COLS))
            check_eq("rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'(exp_rgb(exp_row, n_sclk, exp_plane)));
          else
            check_eq("sclk_count_over", 32'(n_sclk + 1), 32'(COLS));
          n_sclk++;
        end
        if (lat) begin
          check_eq("lat_single", 32'(lat_prev), 0);
          check_eq("lat_oe", 32'(oe), 1);
          check_eq("lat_row_addr", 32'(row_addr), 32'(exp_row));
          check_eq("lat_n_rd", 32'(n_rd), 32'(COLS));
          check_eq("lat_n_sclk", 32'(n_sclk), 32'(COLS));
          check_eq("lat_offset", 32'(cyc - rd_start), 32'(2 * COLS + 3));
          lat_cnt++;
          rd_start = -1; n_rd = 0; n_sclk = 0;
        end else begin
          check_eq("row_addr_hold", 32'(row_addr), 32'(ra_prev));
        end
        sclk_prev = sclk; oe_prev = oe; lat_prev = lat; ra_prev = row_addr;
      end
    end
  end

  task automatic tick();
    @(negedge clk_shift);
    #1;
  endtask

  task automatic randomize_mem();
    for (int r = 0; r < int'(NROWS); r++)
      for (int c = 0; c < int'(COLS); c++) begin
        mem_top[r][c] = pix_t'($urandom);
        mem_bot[r][c] = pix_t'($urandom);
      end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 100) begin tick(); t++; end
    check_eq(tag, 32'(busy), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : sequencer
    int t, c0, l0, last_sc, nsc;
    logic [3:0] r0s;

    randomize_mem();
    // Row 0: plane-0 field of the top half is R on odd columns only.
    for (int c = 0; c < int'(COLS); c++)
      mem_top[0][c] = (pix_t'($urandom) & ~pix_t'(7)) | ((c % 2 == 1) ? pix_t'(4) : pix_t'(0));

    repeat (3) tick();
    check_eq("rst_oe", 32'(oe), 1);
    check_eq("rst_lat", 32'(lat), 0);
    check_eq("rst_sclk", 32'(sclk), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_row_addr", 32'(row_addr), 0);
    check_eq("rst_pix_rd", 32'(fb.pix_rd), 0);
    check_eq("rst_rgb", 32'({r0, g0, b0, r1, g1, b1}), 0);
    rst = 1'b0;
    en  = 1'b1;

    // First shift: odd-column R pattern, 4 pulses, last pulse on cycle 9.
    t = 0;
    while (!fb.pix_rd && t < 20) begin tick(); t++; end
    check_eq("t2_first_rd_seen", 32'(fb.pix_rd), 1);
    check_eq("t2_first_row", 32'(fb.pix_row), 0);
    check_eq("t2_first_col", 32'(fb.pix_col), 0);
    nsc = 0; r0s = '0; last_sc = -1;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (sclk) begin
        if (nsc < 4) r0s[nsc] = r0;
        nsc++;
        last_sc = i;
      end
      if (lat) check_eq("t2_lat_cycle", 32'(i), 32'(2 * COLS + 3));
    end
    check_eq("t2_sclk_pulses", 32'(nsc), 32'(COLS));
    check_eq("t2_r0_samples", 32'(r0s), 32'(4'b1010));
    check_eq("t2_last_sclk_cycle", 32'(last_sc), 32'(2 * COLS + 1));

    // Continuous enable: frame period and latches per frame.
    t = 0;
    while (!frame_done && t < 300) begin tick(); t++; end
    check_eq("t4_fd1_seen", 32'(frame_done), 1);
    c0 = cyc; l0 = lat_cnt;
    t = 0;
    do begin tick(); t++; end while (!frame_done && t < 300);
    check_eq("t4_fd2_seen", 32'(frame_done), 1);
    check_eq("t4_frame_period", 32'(cyc - c0), 32'(NROWS * (PLANES * (2 * COLS + 4)) + NROWS * BASE_ON * ((1 << PLANES) - 1)));
    check_eq("t4_lat_per_frame", 32'(lat_cnt - l0), 32'(NROWS * PLANES));
    t = 0;
    while (!lat && t < 30) begin tick(); t++; end
    check_eq("t4_lat_seen", 32'(lat), 1);
    check_eq("t4_row_after_wrap", 32'(row_addr), 0);

    // Asynchronous reset while row 2 is lit.
    t = 0;
    while (!(row_addr == 2 && !oe) && t < 200) begin tick(); t++; end
    check_eq("t1_lit_row2_seen", 32'(oe), 0);
    #2 rst = 1'b1;
    #1;
    check_eq("t1_async_oe", 32'(oe), 1);
    check_eq("t1_lat", 32'(lat), 0);
    check_eq("t1_sclk", 32'(sclk), 0);
    check_eq("t1_frame_done", 32'(frame_done), 0);
    check_eq("t1_busy", 32'(busy), 0);
    check_eq("t1_row_addr", 32'(row_addr), 0);
    tick(); tick();
    rst = 1'b0;
    t = 0;
    while (!fb.pix_rd && t < 20) begin tick(); t++; end
    check_eq("t1_rd_seen", 32'(fb.pix_rd), 1);
    check_eq("t1_rd_row", 32'(fb.pix_row), 0);
    check_eq("t1_rd_col", 32'(fb.pix_col), 0);

    // Drop enable during the shift of row 1 plane 0.
    t = 0;
    while (!(fb.pix_rd && fb.pix_row == 1 && exp_plane == 0) && t < 200) begin tick(); t++; end
    check_eq("t5_row1_shift_seen", 32'(fb.pix_row), 1);
    l0 = lat_cnt;
    en = 1'b0;
    wait_idle("t5_goes_idle");
    check_eq("t5_one_latch", 32'(lat_cnt - l0), 1);
    check_eq("t5_row_addr", 32'(row_addr), 1);
    check_eq("t5_oe_idle", 32'(oe), 1);
    repeat (5) tick();
    check_eq("t5_stays_idle", 32'(busy), 0);

    // Bottom half blue on every plane, top half dark.
    for (int r = 0; r < int'(NROWS); r++)
      for (int c = 0; c < int'(COLS); c++) begin
        mem_top[r][c] = '0;
        mem_bot[r][c] = '0;
        for (int p = 0; p < int'(PLANES); p++)
          mem_bot[r][c] = mem_bot[r][c] | (pix_t'(1) << (3 * p));
      end
    en = 1'b1;
    t = 0;
    while (!fb.pix_rd && t < 10) begin tick(); t++; end
    check_eq("t5_resume_rd", 32'(fb.pix_rd), 1);
    check_eq("t5_resume_row", 32'(fb.pix_row), 1);
    check_eq("t5_resume_col", 32'(fb.pix_col), 0);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (sclk) begin
        check_eq("t6_b1", 32'(b1), 1);
        check_eq("t6_others", 32'({r0, g0, b0, r1, g1}), 0);
      end
    end

    // Random data with randomly toggled enable.
    en = 1'b0;
    wait_idle("rnd_pre_idle");
    randomize_mem();
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if ($urandom_range(0, 24) == 0) en = ~en;
    end
    en = 1'b0;
    wait_idle("rnd_final_idle");
    check_eq("rnd_final_oe", 32'(oe), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
